// File: rtl/xserial_pkg.sv
// Shared frame constants, FSM state encoding and the flow-message builder
// used by the serial frame transmitter, its interface and its bench.
package xserial_pkg;

    localparam int FRAME_W = 12;

    localparam logic [1:0] KIND_DATA = 2'b00;
    localparam logic [1:0] KIND_MSG  = 2'b01;

    localparam logic [7:0] FLOW_PAYLOAD_HALT   = 8'h01;
    localparam logic [7:0] FLOW_PAYLOAD_RESUME = 8'h00;

    localparam logic [3:0] LAST_IDX = 4'(FRAME_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_GAP
    } tx_state_e;

    // Flow messages always target destination 00.
    function automatic logic [FRAME_W-1:0] flow_msg(input logic halt);
        return {KIND_MSG, 2'b00, (halt ? FLOW_PAYLOAD_HALT : FLOW_PAYLOAD_RESUME)};
    endfunction

endpackage

// File: rtl/xserial_frame_tx_if.sv
// Frame-input, flow-control and serial-line bundle of the frame transmitter.
// slave = transmitter side, master = driver/bench side.
interface xserial_frame_tx_if;
    import xserial_pkg::*;

    logic [FRAME_W-1:0] in_data;
    logic               in_valid;
    logic               in_ack;
    logic               full;
    logic               halted;
    logic               flow_req;
    logic               flow_halt;
    logic               flow_ack;
    logic               out_data;
    logic               busy;

    modport slave (
        input  in_data, in_valid, halted, flow_req, flow_halt,
        output in_ack, full, flow_ack, out_data, busy
    );

    modport master (
        output in_data, in_valid, halted, flow_req, flow_halt,
        input  in_ack, full, flow_ack, out_data, busy
    );

endinterface

// File: rtl/xserial_tx_fifo.sv
// Synchronous count-based frame queue; head visible the cycle after a push.
// Push is ignored while full (even with a same-cycle pop); pop ignored while empty.
module xserial_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 12
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_dat_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, empty_q;
    logic             push_ok, pop_ok;

    assign push_ok = push_i & ~full_q;
    assign pop_ok  = pop_i & ~empty_q;

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CNT_W'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = empty_q;

endmodule

// File: rtl/xserial_frame_tx.sv
// Queues 12-bit frames and serialises start/12 data MSB-first/even parity/stop; start bit
// appears two edges after acceptance into an idle block. Backpressure: in_ack drops while the queue is full.
module xserial_frame_tx
    import xserial_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_BITS   = 1
) (
    input  logic               clock,
    input  logic               reset,
    xserial_frame_tx_if.slave  bus
);

    localparam logic [1:0] GAP_LOAD = 2'(GAP_BITS - 1);

    tx_state_e          state_q;
    logic [FRAME_W-1:0] shift_q;
    logic [3:0]         idx_q;
    logic [1:0]         gap_q;
    logic               pending_q;
    logic               is_flow_q;
    logic               out_q;
    logic               flow_ack_q;

    logic [FRAME_W-1:0] fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               launch_ok;
    logic               launch_flow;
    logic               launch_data;
    logic               launch;
    logic [FRAME_W-1:0] next_frame;

    xserial_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (FRAME_W)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_i     (bus.in_ack),
        .push_dat_i (bus.in_data),
        .pop_i      (launch_data),
        .head_dat_o (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // The last gap cycle acts as an idle decision point so that back-to-back
    // frames are separated by exactly GAP_BITS high bits, not GAP_BITS+1.
    always_comb begin
        launch_ok   = (state_q == ST_IDLE) || ((state_q == ST_GAP) && (gap_q == '0));
        launch_flow = launch_ok & pending_q;
        launch_data = launch_ok & ~pending_q & ~fifo_empty & ~bus.halted;
        launch      = launch_flow | launch_data;
        next_frame  = launch_flow ? flow_msg(bus.flow_halt) : fifo_head;
    end

    // The line is registered, so each state's bit shows in the following cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            gap_q      <= '0;
            pending_q  <= 1'b0;
            is_flow_q  <= 1'b0;
            out_q      <= 1'b1;
            flow_ack_q <= 1'b0;
        end else begin
            flow_ack_q <= 1'b0;
            pending_q  <= launch_flow ? 1'b0 : (pending_q | bus.flow_req);
            unique case (state_q)
                ST_IDLE, ST_GAP: begin
                    out_q <= 1'b1;
                    if ((state_q == ST_GAP) && (gap_q != '0)) begin
                        gap_q <= gap_q - 2'd1;
                    end else if (launch) begin
                        state_q   <= ST_START;
                        shift_q   <= next_frame;
                        is_flow_q <= launch_flow;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_START: begin
                    out_q   <= 1'b0;
                    idx_q   <= LAST_IDX;
                    state_q <= ST_DATA;
                end
                ST_DATA: begin
                    out_q <= shift_q[idx_q];
                    if (idx_q == '0) state_q <= ST_PARITY;
                    else             idx_q   <= idx_q - 4'd1;
                end
                ST_PARITY: begin
                    out_q   <= ^shift_q;
                    state_q <= ST_STOP;
                end
                ST_STOP: begin
                    out_q      <= 1'b1;
                    flow_ack_q <= is_flow_q;
                    gap_q      <= GAP_LOAD;
                    state_q    <= ST_GAP;
                end
                default: begin
                    out_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ack   = bus.in_valid & ~fifo_full;
    assign bus.full     = fifo_full;
    assign bus.out_data = out_q;
    assign bus.flow_ack = flow_ack_q;
    assign bus.busy     = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_xserial_frame_tx.sv
// Directed bench for the serial frame transmitter: a line receiver model decodes
// frames on the falling edge; each scenario compares against hand-computed values.
module tb_xserial_frame_tx;

    logic clock;
    logic reset;

    xserial_frame_tx_if bus();

    xserial_frame_tx #(
        .FIFO_DEPTH (4),
        .GAP_BITS   (1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Receiver model: samples the line mid-cycle.
    logic [11:0] rx_dat[$];
    logic        rx_ok[$];
    logic        rx_fack[$];
    int          rx_gap[$];
    int          fack_cnt = 0;
    logic        rx_busy  = 1'b0;
    int          rx_n     = 0;
    int          idle_run = 0;
    logic [11:0] rx_sh    = '0;
    logic        rx_par   = 1'b0;

    always @(negedge clock) begin
        if (bus.flow_ack === 1'b1) fack_cnt++;
        if (reset !== 1'b1) begin
            rx_busy  = 1'b0;
            idle_run = 0;
        end else if (!rx_busy) begin
            if (bus.out_data === 1'b0) begin
                rx_busy = 1'b1;
                rx_n    = 0;
                rx_gap.push_back(idle_run);
            end else begin
                idle_run++;
            end
        end else begin
            if (rx_n < 12) begin
                rx_sh = {rx_sh[10:0], bus.out_data};
            end else if (rx_n == 12) begin
                rx_par = bus.out_data;
            end else begin
                rx_dat.push_back(rx_sh);
                rx_ok.push_back((rx_par == ^rx_sh) && (bus.out_data == 1'b1));
                rx_fack.push_back(bus.flow_ack);
                rx_busy  = 1'b0;
                idle_run = 0;
            end
            rx_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [11:0] d);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_frames(input string tag, input int n);
        int k = 0;
        while (rx_dat.size() < n && k < 400) begin
            tick();
            k++;
        end
        chk(tag, rx_dat.size(), n);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (bus.busy !== 1'b0 && k < 400) begin
            tick();
            k++;
        end
        chk(tag, bus.busy, 0);
        repeat (2) tick();
    endtask

    task automatic clear_rx();
        rx_dat.delete();
        rx_ok.delete();
        rx_fack.delete();
        rx_gap.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    logic [11:0] exp5 [5];
    logic [13:0] bits;
    int          refused;
    int          f0;
    int          lows;

    initial begin
        exp5 = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h555};
        reset         = 1'b1;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.halted    = 1'b0;
        bus.flow_req  = 1'b0;
        bus.flow_halt = 1'b0;
        #1;

        // Reset state
        reset        = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        tick();
        chk("rst_out_data", bus.out_data, 1);
        chk("rst_full",     bus.full,     0);
        chk("rst_flow_ack", bus.flow_ack, 0);
        chk("rst_busy",     bus.busy,     0);
        chk("rst_in_ack_hi", bus.in_ack,  1);
        bus.in_valid = 1'b0;
        #1;
        chk("rst_in_ack_lo", bus.in_ack,  0);
        tick();
        reset = 1'b1;
        repeat (3) tick();

        // Single frame 12'h3C1: latency and exact bit sequence
        bus.in_data  = 12'h3C1;
        bus.in_valid = 1'b1;
        #1;
        chk("t1_in_ack", bus.in_ack, 1);
        tick();
        bus.in_valid = 1'b0;
        chk("t1_busy",    bus.busy,     1);
        chk("t1_line_k",  bus.out_data, 1);
        tick();
        chk("t1_line_k1", bus.out_data, 1);
        tick();
        chk("t1_start_k2", bus.out_data, 0);
        for (int i = 13; i >= 0; i--) begin
            tick();
            bits[i] = bus.out_data;
        end
        chk("t1_bits", bits, 14'b0011_1100_0001_11);
        tick();
        chk("t1_idle_after", bus.out_data, 1);
        chk("t1_busy_end",   bus.busy,     0);
        wait_idle("t1_idle");
        clear_rx();

        // Fill the queue behind a busy transmitter; fifth push waits for the first pop
        push(12'h0F0);
        tick();
        tick();
        for (int i = 0; i < 4; i++) push(exp5[i]);
        chk("t2_full", bus.full, 1);
        bus.in_data  = exp5[4];
        bus.in_valid = 1'b1;
        #1;
        chk("t2_fifth_refused", bus.in_ack, 0);
        refused = 0;
        while (bus.in_ack !== 1'b1 && refused < 40) begin
            tick();
            refused++;
        end
        chk("t2_refused_cycles", refused, 11);
        tick();
        bus.in_valid = 1'b0;
        chk("t2_full_again", bus.full, 1);
        wait_frames("t2_frames", 6);
        chk("t2_first", rx_dat[0], 12'h0F0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_dat%0d", i), rx_dat[i+1], exp5[i]);
            chk($sformatf("t2_gap%0d", i), rx_gap[i+1], 1);
            chk($sformatf("t2_ok%0d",  i), rx_ok[i+1],  1);
        end
        wait_idle("t2_idle");
        clear_rx();

        // Halt holds data frames; flow halt message still goes out
        bus.halted = 1'b1;
        push(12'hA11);
        push(12'hA22);
        repeat (6) tick();
        chk("t3_held_none", rx_dat.size(), 0);
        chk("t3_busy_held", bus.busy, 1);
        f0 = fack_cnt;
        bus.flow_halt = 1'b1;
        bus.flow_req  = 1'b1;
        tick();
        bus.flow_req  = 1'b0;
        wait_frames("t3_msg", 1);
        chk("t3_msg_dat",  rx_dat[0],  12'h401);
        chk("t3_msg_fack", rx_fack[0], 1);
        chk("t3_msg_ok",   rx_ok[0],   1);
        repeat (30) tick();
        chk("t3_still_held", rx_dat.size(), 1);
        chk("t3_fack_cnt", fack_cnt - f0, 1);
        bus.halted    = 1'b0;
        bus.flow_halt = 1'b0;
        wait_frames("t3_resume", 3);
        chk("t3_dat1", rx_dat[1], 12'hA11);
        chk("t3_dat2", rx_dat[2], 12'hA22);
        wait_idle("t3_idle");
        clear_rx();

        // Halt raised at data index 5: current frame completes, next one waits
        push(12'h5A5);
        push(12'h0C3);
        repeat (7) tick();
        bus.halted = 1'b1;
        repeat (40) tick();
        chk("t4_count",   rx_dat.size(), 1);
        chk("t4_dat",     rx_dat[0],     12'h5A5);
        chk("t4_ok",      rx_ok[0],      1);
        chk("t4_busy",    bus.busy,      1);
        chk("t4_line_hi", bus.out_data,  1);
        bus.halted = 1'b0;
        wait_frames("t4_resume", 2);
        chk("t4_dat2", rx_dat[1], 12'h0C3);
        wait_idle("t4_idle");
        clear_rx();

        // Three flow requests during one data frame collapse into one message
        f0 = fack_cnt;
        push(12'h777);
        repeat (4) tick();
        repeat (3) begin
            bus.flow_req = 1'b1;
            tick();
            bus.flow_req = 1'b0;
            tick();
        end
        wait_frames("t5_frames", 2);
        repeat (40) tick();
        chk("t5_count",   rx_dat.size(), 2);
        chk("t5_dat0",    rx_dat[0],     12'h777);
        chk("t5_dat1",    rx_dat[1],     12'h400);
        chk("t5_fack0",   rx_fack[0],    0);
        chk("t5_fack1",   rx_fack[1],    1);
        chk("t5_gap1",    rx_gap[1],     1);
        chk("t5_fack_cnt", fack_cnt - f0, 1);
        wait_idle("t5_idle");
        clear_rx();

        // Reset at data index 7 of 12'h0A5 abandons the frame
        push(12'h0A5);
        repeat (6) tick();
        chk("t6_line_pre", bus.out_data, 0);
        reset = 1'b0;
        #1;
        chk("t6_rst_line",  bus.out_data, 1);
        chk("t6_rst_busy",  bus.busy,     0);
        chk("t6_rst_full",  bus.full,     0);
        chk("t6_rst_fack",  bus.flow_ack, 0);
        tick();
        tick();
        reset = 1'b1;
        repeat (3) tick();
        chk("t6_post_busy", bus.busy,     0);
        chk("t6_post_line", bus.out_data, 1);
        lows = 0;
        repeat (30) begin
            tick();
            if (bus.out_data !== 1'b1) lows++;
        end
        chk("t6_line_lows", lows, 0);
        chk("t6_no_frames", rx_dat.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
